// File: rtl/lvds_pwm_pkg.sv
// Shared types and default constants for the multi-channel differential PWM driver.
//   phase_e        : per-channel output phase (NONE / DEAD / P / N)
//   DEF_*          : default parameter values used by the top and the interface
//   ch_width()     : width of a channel-select field (never below 1 bit)
package lvds_pwm_pkg;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_DEAD = 2'd1,
    PH_P    = 2'd2,
    PH_N    = 2'd3
  } phase_e;

  localparam int unsigned DEF_CHANNELS  = 4;
  localparam int unsigned DEF_CNT_W     = 26;
  localparam int unsigned DEF_PERIOD    = 30000000;
  localparam int unsigned DEF_DUTY_W    = 4;
  localparam int unsigned DEF_DEADTIME  = 0;
  localparam int unsigned DEF_DUTY_INIT = 8;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lvds_pwm_array_if.sv
// Duty-write bus from the board controls / CPU into the PWM array.
//   DUTY_WR  : single-cycle write strobe
//   DUTY_CH  : target channel (out-of-range values are ignored by the slave)
//   DUTY_VAL : duty code to place in the pending register
// Modports: master drives the write, slave (the PWM array) receives it.
interface lvds_pwm_array_if
  import lvds_pwm_pkg::*;
#(
  parameter int unsigned CH_W   = ch_width(DEF_CHANNELS),
  parameter int unsigned DUTY_W = DEF_DUTY_W
);

  logic              DUTY_WR;
  logic [CH_W-1:0]   DUTY_CH;
  logic [DUTY_W-1:0] DUTY_VAL;

  modport master (output DUTY_WR, DUTY_CH, DUTY_VAL);
  modport slave  (input  DUTY_WR, DUTY_CH, DUTY_VAL);

endinterface

// File: rtl/lvds_pwm_channel.sv
// One differential PWM channel: threshold register, comparator and dead-time FSM.
//   clk, rst : clock, asynchronous active-high reset
//   run      : counting enabled; low forces the FSM to NONE with both legs low
//   commit   : load a new threshold from duty (period boundary)
//   count    : (effective) period count for this channel
//   duty     : duty code to commit
//   tx_p/n   : registered positive / negative legs, never high together
module lvds_pwm_channel
  import lvds_pwm_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned DUTY_W    = DEF_DUTY_W,
  parameter int unsigned DEADTIME  = DEF_DEADTIME,
  parameter int unsigned DUTY_INIT = DEF_DUTY_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              commit,
  input  logic [CNT_W-1:0]  count,
  input  logic [DUTY_W-1:0] duty,
  output logic              tx_p,
  output logic              tx_n
);

  localparam int unsigned PROD_W = CNT_W + DUTY_W;
  localparam int unsigned DT_W   = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  // Full-width product, then scale down by 2^DUTY_W.
  function automatic logic [CNT_W-1:0] threshold(input logic [DUTY_W-1:0] d);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(PERIOD) * PROD_W'(d);
    return CNT_W'(prod >> DUTY_W);
  endfunction

  phase_e            state;
  phase_e            target;
  phase_e            want;
  logic [DT_W-1:0]   dcnt;
  logic [CNT_W-1:0]  thr;

  // Desired phase for the current count; duty 0 gives thr 0, so always N.
  assign want = (count < thr) ? PH_P : PH_N;

  // Dead-time FSM: any phase change passes through DEAD for DEADTIME cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PH_NONE;
      target <= PH_NONE;
      dcnt   <= DT_W'(DEADTIME);
      thr    <= threshold(DUTY_W'(DUTY_INIT));
      tx_p   <= 1'b0;
      tx_n   <= 1'b0;
    end else begin
      if (commit) begin
        thr <= threshold(duty);
      end
      if (!run) begin
        state <= PH_NONE;
        dcnt  <= DT_W'(DEADTIME);
        tx_p  <= 1'b0;
        tx_n  <= 1'b0;
      end else begin
        case (state)
          PH_DEAD: begin
            if (want != target) begin
              // target moved while waiting: restart the gap toward it
              target <= want;
              dcnt   <= DT_W'(DEADTIME);
            end else if (dcnt <= DT_W'(1)) begin
              state <= target;
              tx_p  <= (target == PH_P);
              tx_n  <= (target == PH_N);
            end else begin
              dcnt <= dcnt - DT_W'(1);
            end
          end
          default: begin
            if (want != state) begin
              if (DEADTIME == 0) begin
                state <= want;
                tx_p  <= (want == PH_P);
                tx_n  <= (want == PH_N);
              end else begin
                state  <= PH_DEAD;
                target <= want;
                dcnt   <= DT_W'(DEADTIME);
                tx_p   <= 1'b0;
                tx_n   <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/lvds_pwm_array.sv
// Multi-channel differential PWM driver for the HSMC LVDS TX pairs.
//   OSC_50_B8A  : 50 MHz system clock
//   RESET       : asynchronous active-high reset (release synchronised internally)
//   EN          : global enable; low holds the counter at 0 and all legs low
//   duty_bus    : duty write bus (slave modport): DUTY_WR / DUTY_CH / DUTY_VAL
//   HSMC_TX_p/n : registered differential legs, one bit per channel
//   PERIOD_TICK : high on the cycle the period counter is at PERIOD-1
//   LED         : [0] ch0 P, [1] ch0 N, [2] EN (registered), [3] uncommitted write pending
// Optional build macro LVDS_PWM_PHASE_STAGGER_EN offsets channel k by
// k*(PERIOD/CHANNELS) counts; duty commit stays on the global wrap.
module lvds_pwm_array
  import lvds_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS  = DEF_CHANNELS,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned DUTY_W    = DEF_DUTY_W,
  parameter int unsigned DEADTIME  = DEF_DEADTIME,
  parameter int unsigned DUTY_INIT = DEF_DUTY_INIT
) (
  input  logic                OSC_50_B8A,
  input  logic                RESET,
  input  logic                EN,
  lvds_pwm_array_if.slave     duty_bus,
  output logic [CHANNELS-1:0] HSMC_TX_p,
  output logic [CHANNELS-1:0] HSMC_TX_n,
  output logic                PERIOD_TICK,
  output logic [3:0]          LED
);

  localparam int unsigned CH_W = ch_width(CHANNELS);

  logic                rst_hold;
  logic                run;
  logic                commit;
  logic [CNT_W-1:0]    count;
  logic                en_q;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] dirty;
  logic [DUTY_W-1:0]   pending [CHANNELS];

  // Reset release synchroniser: asserts with RESET, drops on the first edge after it.
  always_ff @(posedge OSC_50_B8A or posedge RESET) begin
    if (RESET) begin
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
    end
  end

  assign run    = EN && !rst_hold;
  assign commit = run && (count == CNT_W'(PERIOD - 1));

  // Period counter and tick; tick is set one edge early so it lines up with PERIOD-1.
  always_ff @(posedge OSC_50_B8A or posedge RESET) begin
    if (RESET) begin
      count       <= '0;
      PERIOD_TICK <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      en_q <= EN;
      if (!run) begin
        count       <= '0;
        PERIOD_TICK <= 1'b0;
      end else begin
        count       <= commit ? '0 : count + CNT_W'(1);
        PERIOD_TICK <= (count == CNT_W'(PERIOD - 2));
      end
    end
  end

  // Pending duty registers; a write in the commit cycle is folded into the commit.
  always_ff @(posedge OSC_50_B8A or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= DUTY_W'(DUTY_INIT);
      end
      dirty <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit[i]) begin
          pending[i] <= duty_bus.DUTY_VAL;
        end
      end
      dirty <= commit ? '0 : (dirty | wr_hit);
    end
  end

  assign LED = {|dirty, en_q, HSMC_TX_n[0], HSMC_TX_p[0]};

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [CNT_W-1:0]  eff;
    logic [DUTY_W-1:0] duty_in;

    // Out-of-range channel numbers match no k and are dropped.
    assign wr_hit[k] = duty_bus.DUTY_WR && (duty_bus.DUTY_CH == CH_W'(k));
    assign duty_in   = wr_hit[k] ? duty_bus.DUTY_VAL : pending[k];

`ifdef LVDS_PWM_PHASE_STAGGER_EN
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned OFS   = k * (PERIOD / CHANNELS);
    logic [SUM_W-1:0] sum;
    assign sum = SUM_W'(count) + SUM_W'(OFS);
    assign eff = (sum >= SUM_W'(PERIOD)) ? CNT_W'(sum - SUM_W'(PERIOD)) : CNT_W'(sum);
`else
    assign eff = count;
`endif

    lvds_pwm_channel #(
      .CNT_W    (CNT_W),
      .PERIOD   (PERIOD),
      .DUTY_W   (DUTY_W),
      .DEADTIME (DEADTIME),
      .DUTY_INIT(DUTY_INIT)
    ) u_ch (
      .clk   (OSC_50_B8A),
      .rst   (RESET),
      .run   (run),
      .commit(commit),
      .count (eff),
      .duty  (duty_in),
      .tx_p  (HSMC_TX_p[k]),
      .tx_n  (HSMC_TX_n[k])
    );
  end

endmodule

// File: tb/tb_lvds_pwm_array.sv
// Bench for lvds_pwm_array: a cycle-level model of the PWM rules
// (count, threshold, "a phase is driven once desired for more than DEADTIME
// consecutive evaluations", double-buffered duty) plus literal window counts.
module tb_lvds_pwm_array;

  localparam int unsigned CH    = 3;
  localparam int unsigned CW    = 6;
  localparam int unsigned PER   = 32;
  localparam int unsigned DW    = 4;
  localparam int unsigned DT    = 2;
  localparam int unsigned DINIT = 8;
  localparam int unsigned CHW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic [CH-1:0] tx_p;
  logic [CH-1:0] tx_n;
  logic          tick;
  logic [3:0]    led;

  lvds_pwm_array_if #(.CH_W(CHW), .DUTY_W(DW)) bus ();

  lvds_pwm_array #(
    .CHANNELS (CH),
    .CNT_W    (CW),
    .PERIOD   (PER),
    .DUTY_W   (DW),
    .DEADTIME (DT),
    .DUTY_INIT(DINIT)
  ) dut (
    .OSC_50_B8A (clk),
    .RESET      (rst),
    .EN         (en),
    .duty_bus   (bus),
    .HSMC_TX_p  (tx_p),
    .HSMC_TX_n  (tx_n),
    .PERIOD_TICK(tick),
    .LED        (led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt = 0;
  int m_pend [CH];
  int m_act [CH];
  bit m_dirty [CH];
  bit m_sync = 1'b0;
  bit m_live [CH];
  bit m_prevd [CH];
  int m_streak [CH];
  bit e_p [CH];
  bit e_n [CH];
  bit e_tick = 1'b0;
  bit e_en = 1'b0;
  bit m_run, m_wr, m_d;
  int m_wch;

  function automatic int thr_of(input int d);
    return (PER * d) / (1 << DW);
  endfunction

  function automatic int eff_of(input int c, input int k);
`ifdef LVDS_PWM_PHASE_STAGGER_EN
    return (c + k * (PER / CH)) % PER;
`else
    return c + 0 * k;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_sync = 0; e_tick = 0; e_en = 0;
      for (int k = 0; k < CH; k++) begin
        m_pend[k] = DINIT; m_act[k] = DINIT; m_dirty[k] = 0;
        m_live[k] = 0; m_streak[k] = 0; e_p[k] = 0; e_n[k] = 0;
      end
    end else begin
      m_run = en && m_sync;
      m_wch = int'(bus.DUTY_CH);
      m_wr  = bus.DUTY_WR && (m_wch < CH);
      if (m_wr) m_pend[m_wch] = int'(bus.DUTY_VAL);
      if (m_run) begin
        for (int k = 0; k < CH; k++) begin
          m_d = eff_of(m_cnt, k) < thr_of(m_act[k]);
          if (!m_live[k] || m_d != m_prevd[k]) m_streak[k] = 1;
          else if (m_streak[k] <= DT) m_streak[k]++;
          m_live[k] = 1; m_prevd[k] = m_d;
          e_p[k] = m_d && (m_streak[k] > DT);
          e_n[k] = !m_d && (m_streak[k] > DT);
        end
        if (m_cnt == PER - 1) begin
          for (int k = 0; k < CH; k++) begin m_act[k] = m_pend[k]; m_dirty[k] = 0; end
          m_cnt = 0;
        end else begin
          if (m_wr) m_dirty[m_wch] = 1;
          m_cnt++;
        end
      end else begin
        for (int k = 0; k < CH; k++) begin m_live[k] = 0; e_p[k] = 0; e_n[k] = 0; end
        if (m_wr) m_dirty[m_wch] = 1;
        m_cnt = 0;
      end
      e_tick = (m_cnt == PER - 1);
      e_en   = en;
      m_sync = 1;
    end
  end

  // Compare process: every cycle, shortly after the active edge.
  logic [3:0] e_led;
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < CH; k++) begin
      check($sformatf("model tx_p[%0d]", k), 32'(tx_p[k]), 32'(e_p[k]));
      check($sformatf("model tx_n[%0d]", k), 32'(tx_n[k]), 32'(e_n[k]));
    end
    e_led = {(m_dirty[0] | m_dirty[1] | m_dirty[2]), e_en, e_n[0], e_p[0]};
    check("model tick", 32'(tick), 32'(e_tick));
    check("model led", 32'(led), 32'(e_led));
    check("no_overlap", 32'(tx_p & tx_n), 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  int w_p [CH];
  int w_n [CH];
  int w_low [CH];
  int w_tick;

  task automatic measure(input int n);
    for (int k = 0; k < CH; k++) begin w_p[k] = 0; w_n[k] = 0; w_low[k] = 0; end
    w_tick = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < CH; k++) begin
        if (tx_p[k]) w_p[k]++;
        else if (tx_n[k]) w_n[k]++;
        else w_low[k]++;
      end
      if (tick) w_tick++;
      @(negedge clk);
    end
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < 200 && m_cnt != c; i++) @(negedge clk);
    check($sformatf("wait_cnt %0d", c), 32'(m_cnt), 32'(c));
  endtask

  task automatic wr(input int ch, input int v);
    bus.DUTY_WR  = 1'b1;
    bus.DUTY_CH  = CHW'(ch);
    bus.DUTY_VAL = DW'(v);
    @(negedge clk);
    bus.DUTY_WR  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DUTY_WR = 1'b0; bus.DUTY_CH = '0; bus.DUTY_VAL = '0;
    repeat (3) @(negedge clk);
    check("reset tx_p", 32'(tx_p), 32'd0);
    check("reset tx_n", 32'(tx_n), 32'd0);
    check("reset led", 32'(led), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    rst = 1'b0;

    // Steady duty 8: P 14, N 14, low 4, one tick per period.
    repeat (8) @(negedge clk);
    measure(PER);
    check("init ch0 P", w_p[0], 14);
    check("init ch0 N", w_n[0], 14);
    check("init ch0 low", w_low[0], 4);
    check("init ch1 P", w_p[1], 14);
    check("init tick", w_tick, 1);

    // ch1 = 4 written mid-period, committed at the wrap.
    wait_cnt(10);
    wr(1, 4);
    check("pending led3", 32'(led[3]), 32'd1);
    wait_cnt(0);
    check("commit led3", 32'(led[3]), 32'd0);
    wait_cnt(1);
    measure(PER);
    check("duty4 ch1 P", w_p[1], 6);
    check("duty4 ch1 N", w_n[1], 22);
    check("duty4 ch0 P", w_p[0], 14);

    // ch0 = 0 then 15 in the commit cycle: 15 wins.
    wait_cnt(5);
    wr(0, 0);
    wait_cnt(31);
    wr(0, 15);
    wait_cnt(1);
    measure(PER);
    check("duty15 ch0 P", w_p[0], 28);

    // ch0 = 0: N steady across wraps.
    wait_cnt(3);
    wr(0, 0);
    wait_cnt(1);
    @(negedge clk);
    wait_cnt(1);
    measure(PER);
    check("duty0 ch0 P", w_p[0], 0);
    check("duty0 ch0 N", w_n[0], 32);
    check("duty0 ch0 low", w_low[0], 0);

    // EN drop at count 20 and restart.
    wait_cnt(20);
    en = 1'b0;
    @(negedge clk);
    check("en_off tx_p", 32'(tx_p), 32'd0);
    check("en_off tx_n", 32'(tx_n), 32'd0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("en_on dead1", 32'(tx_p | tx_n), 32'd0);
    @(negedge clk);
    check("en_on dead2", 32'(tx_p | tx_n), 32'd0);
    @(negedge clk);
    check("en_on ch1 P", 32'(tx_p[1]), 32'd1);
    check("en_on ch0 N", 32'(tx_n[0]), 32'd1);

    // Out-of-range channel is ignored.
    wr(3, 1);
    check("ch3 ignored led3", 32'(led[3]), 32'd0);

    // Random writes.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end
    repeat (40) @(negedge clk);

    // Mid-period reset drops outputs at once and loses the pending write.
    wr(0, 2);
    rst = 1'b1;
    #1;
    check("async rst tx_p", 32'(tx_p), 32'd0);
    check("async rst tx_n", 32'(tx_n), 32'd0);
    check("async rst led", 32'(led), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    measure(PER);
    check("post rst ch0 P", w_p[0], 14);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
